// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Sits between an SPI slave and a single-port RAM. Edges of rx_valid
//   deliver 10-bit commands {opcode, payload}. Commands either load the
//   write/read pointers or queue one RAM access at the pointer, which then
//   post-increments. A local host shares the RAM port through round-robin
//   arbitration. At most one RAM access is in flight at a time.
//
// Ports
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   rx_data, rx_valid      SPI command stream (acts on rx_valid rising edge)
//   tx_data, tx_valid      SPI read data; valid held until the next command
//   loc_req/we/addr/wdata  local request, held until loc_gnt
//   loc_gnt                one-cycle grant, coincident with the RAM access
//   loc_rdata, loc_rvalid  local read data, one-cycle valid pulse
//   ram_en/we/addr/wdata   registered RAM access port
//   ram_rdata              RAM read data, one cycle after a read strobe
//   spi_ovf                sticky: an SPI access was overwritten before issue
module spi_ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W+1:0] rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              loc_req,
   input  logic              loc_we,
   input  logic [ADDR_W-1:0] loc_addr,
   input  logic [DATA_W-1:0] loc_wdata,
   output logic              loc_gnt,
   output logic [DATA_W-1:0] loc_rdata,
   output logic              loc_rvalid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              spi_ovf
);

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

   state_t            state;
   logic              rx_valid_d;
   logic              cmd_edge;
   logic [1:0]        opcode;
   logic [ADDR_W-1:0] payload;
   logic              spi_cmd;
   logic              spi_sel;

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              spi_pend;
   logic              snap_we;
   logic [ADDR_W-1:0] snap_addr;
   logic [DATA_W-1:0] snap_data;
   logic              last_winner;  // 0 = SPI, 1 = local
   logic              cur_spi;      // winner of the access in flight
   logic              cur_we;

   assign opcode   = rx_data[ADDR_W+1:ADDR_W];
   assign payload  = rx_data[ADDR_W-1:0];
   assign cmd_edge = rx_valid & ~rx_valid_d;
   // Opcodes 01 and 11 are the ones that request a RAM access
   assign spi_cmd  = cmd_edge & opcode[0];
   // SPI wins when it is the only requester, or when local won last time
   assign spi_sel  = spi_pend & (~loc_req | last_winner);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         rx_valid_d  <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         spi_pend    <= 1'b0;
         snap_we     <= 1'b0;
         snap_addr   <= '0;
         snap_data   <= '0;
         last_winner <= 1'b0;
         cur_spi     <= 1'b0;
         cur_we      <= 1'b0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         loc_gnt     <= 1'b0;
         loc_rdata   <= '0;
         loc_rvalid  <= 1'b0;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         spi_ovf     <= 1'b0;
      end else begin
         rx_valid_d <= rx_valid;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         loc_gnt    <= 1'b0;
         loc_rvalid <= 1'b0;

         if (cmd_edge) begin
            tx_valid <= 1'b0;
            case (opcode)
               2'b00: wr_ptr <= payload;
               2'b10: rd_ptr <= payload;
               2'b01: begin
                  snap_we   <= 1'b1;
                  snap_addr <= wr_ptr;
                  snap_data <= payload;
                  wr_ptr    <= wr_ptr + 1'b1;
               end
               default: begin
                  snap_we   <= 1'b0;
                  snap_addr <= rd_ptr;
                  rd_ptr    <= rd_ptr + 1'b1;
               end
            endcase
         end

         if (spi_cmd) begin
            spi_pend <= 1'b1;
            // The snapshot already reached the RAM port once we are in ISSUE
            // for SPI, so only an earlier overwrite counts as an overrun.
            if (spi_pend && !(state == ISSUE && cur_spi))
               spi_ovf <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (spi_pend || loc_req) begin
                  state       <= ISSUE;
                  cur_spi     <= spi_sel;
                  last_winner <= ~spi_sel;
                  ram_en      <= 1'b1;
                  if (spi_sel) begin
                     ram_we    <= snap_we;
                     ram_addr  <= snap_addr;
                     ram_wdata <= snap_data;
                     cur_we    <= snap_we;
                  end else begin
                     ram_we    <= loc_we;
                     ram_addr  <= loc_addr;
                     ram_wdata <= loc_wdata;
                     cur_we    <= loc_we;
                     loc_gnt   <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (cur_spi && !spi_cmd)
                  spi_pend <= 1'b0;
               state <= cur_we ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
               // Placed after the cmd_edge clear so a set in the same cycle wins
               if (cur_spi) begin
                  tx_data  <= ram_rdata;
                  tx_valid <= 1'b1;
               end else begin
                  loc_rdata  <= ram_rdata;
                  loc_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter with a synchronous RAM
// model attached to the RAM port.
module tb_spi_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       loc_req;
   logic       loc_we;
   logic [7:0] loc_addr;
   logic [7:0] loc_wdata;
   logic       loc_gnt;
   logic [7:0] loc_rdata;
   logic       loc_rvalid;
   logic       ram_en;
   logic       ram_we;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic       spi_ovf;

   logic       pre_en;
   logic [7:0] pre_addr;
   logic [7:0] pre_data;
   logic [7:0] mem [256];
   int         wr_cnt = 0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid),
      .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
      .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .loc_rvalid(loc_rvalid),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
   );

   // RAM model: synchronous read, one-cycle latency
   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt <= wr_cnt + 1;
         end else begin
            ram_rdata <= mem[ram_addr];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      tick();
      pre_en   = 1'b0;
   endtask

   task automatic send_edge(input logic [9:0] c);
      rx_data  = c;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({tx_data, tx_valid, loc_gnt, loc_rdata, loc_rvalid, ram_en, ram_we,
           ram_addr, ram_wdata, spi_ovf} !== 38'd0) begin
         bad++;
         $display("FAIL reset_outputs: got tx=%h/%b gnt=%b lr=%h/%b en=%b we=%b a=%h wd=%h ovf=%b want all 0",
                  tx_data, tx_valid, loc_gnt, loc_rdata, loc_rvalid, ram_en, ram_we, ram_addr, ram_wdata, spi_ovf);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_spi_write();
      int w0;
      send_edge(10'h010);
      w0 = wr_cnt;
      rx_data  = 10'h1A5;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick();
      total++;
      if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h10, 8'hA5}) begin
         bad++;
         $display("FAIL spi_write_access: got en=%b we=%b a=%h d=%h want 1 1 10 a5", ram_en, ram_we, ram_addr, ram_wdata);
      end
      tick();
      total++;
      if ({ram_en, ram_we} !== 2'b00) begin
         bad++;
         $display("FAIL spi_write_single: got en=%b we=%b want 0 0", ram_en, ram_we);
      end
      tick();
      total++;
      if (wr_cnt - w0 !== 1) begin
         bad++;
         $display("FAIL spi_write_count: got %0d want 1", wr_cnt - w0);
      end
      send_edge(10'h15A);
      repeat (3) tick();
      total++;
      if (mem[8'h11] !== 8'h5A) begin
         bad++;
         $display("FAIL spi_write_ptr_inc: mem[11] got %h want 5a", mem[8'h11]);
      end
   endtask

   task automatic test_spi_read();
      preload(8'hFF, 8'h3C);
      preload(8'h00, 8'h77);
      send_edge(10'h2FF);
      rx_data  = 10'h300;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick();
      total++;
      if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'hFF}) begin
         bad++;
         $display("FAIL spi_read_access: got en=%b we=%b a=%h want 1 0 ff", ram_en, ram_we, ram_addr);
      end
      tick();
      total++;
      if (tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL spi_read_early: tx_valid got %b want 0", tx_valid);
      end
      tick();
      total++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h3C}) begin
         bad++;
         $display("FAIL spi_read_data: got v=%b d=%h want 1 3c", tx_valid, tx_data);
      end
      repeat (5) tick();
      total++;
      if (tx_valid !== 1'b1) begin
         bad++;
         $display("FAIL spi_read_hold: tx_valid got %b want 1", tx_valid);
      end
      rx_data  = 10'h300;
      rx_valid = 1'b1;
      tick();
      total++;
      if (tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL spi_read_clear: tx_valid got %b want 0", tx_valid);
      end
      rx_valid = 1'b0;
      repeat (4) tick();
      total++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h77}) begin
         bad++;
         $display("FAIL spi_read_wrap: got v=%b d=%h want 1 77", tx_valid, tx_data);
      end
   endtask

   task automatic test_contention();
      send_edge(10'h040);
      preload(8'h20, 8'h99);
      // last winner is SPI: local goes first
      rx_data  = 10'h1BB;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      loc_req  = 1'b1;
      loc_we   = 1'b0;
      loc_addr = 8'h20;
      tick();
      total++;
      if ({loc_gnt, ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b0, 8'h20}) begin
         bad++;
         $display("FAIL contend_local_first: got gnt=%b en=%b we=%b a=%h want 1 1 0 20", loc_gnt, ram_en, ram_we, ram_addr);
      end
      tick();
      loc_req = 1'b0;
      tick();
      total++;
      if ({loc_rvalid, loc_rdata} !== {1'b1, 8'h99}) begin
         bad++;
         $display("FAIL contend_local_rdata: got v=%b d=%h want 1 99", loc_rvalid, loc_rdata);
      end
      tick();
      total++;
      if ({ram_en, ram_we, ram_addr, ram_wdata, loc_gnt, loc_rvalid} !== {1'b1, 1'b1, 8'h40, 8'hBB, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL contend_spi_second: got en=%b we=%b a=%h d=%h gnt=%b rv=%b want 1 1 40 bb 0 0",
                  ram_en, ram_we, ram_addr, ram_wdata, loc_gnt, loc_rvalid);
      end
      tick();
      // lone local write makes local the last winner
      loc_req   = 1'b1;
      loc_we    = 1'b1;
      loc_addr  = 8'h21;
      loc_wdata = 8'h55;
      tick();
      total++;
      if (loc_gnt !== 1'b1) begin
         bad++;
         $display("FAIL local_lone_gnt: got %b want 1", loc_gnt);
      end
      tick();
      loc_req  = 1'b0;
      rx_data  = 10'h1CC;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      loc_req  = 1'b1;
      loc_we   = 1'b0;
      loc_addr = 8'h20;
      tick();
      total++;
      if ({ram_en, ram_we, ram_addr, ram_wdata, loc_gnt} !== {1'b1, 1'b1, 8'h41, 8'hCC, 1'b0}) begin
         bad++;
         $display("FAIL contend_spi_first: got en=%b we=%b a=%h d=%h gnt=%b want 1 1 41 cc 0",
                  ram_en, ram_we, ram_addr, ram_wdata, loc_gnt);
      end
      tick();
      tick();
      total++;
      if ({loc_gnt, ram_addr} !== {1'b1, 8'h20}) begin
         bad++;
         $display("FAIL contend_local_second: got gnt=%b a=%h want 1 20", loc_gnt, ram_addr);
      end
      tick();
      loc_req = 1'b0;
      tick();
      total++;
      if ({loc_rvalid, loc_rdata, mem[8'h21]} !== {1'b1, 8'h99, 8'h55}) begin
         bad++;
         $display("FAIL contend_local_done: got rv=%b d=%h mem21=%h want 1 99 55", loc_rvalid, loc_rdata, mem[8'h21]);
      end
      tick();
   endtask

   task automatic test_held_rx_valid();
      int w0;
      w0 = wr_cnt;
      rx_data  = 10'h177;
      rx_valid = 1'b1;
      repeat (20) tick();
      rx_valid = 1'b0;
      repeat (5) tick();
      total++;
      if (wr_cnt - w0 !== 1) begin
         bad++;
         $display("FAIL held_rx_valid: writes got %0d want 1", wr_cnt - w0);
      end
   endtask

   task automatic test_overrun();
      int w0;
      send_edge(10'h050);
      total++;
      if (spi_ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_before: got %b want 0", spi_ovf);
      end
      w0 = wr_cnt;
      loc_req  = 1'b1;
      loc_we   = 1'b0;
      loc_addr = 8'h20;
      rx_data  = 10'h111;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      total++;
      if (loc_gnt !== 1'b1) begin
         bad++;
         $display("FAIL ovf_local_holds: loc_gnt got %b want 1", loc_gnt);
      end
      tick();
      loc_req  = 1'b0;
      rx_data  = 10'h122;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      total++;
      if (spi_ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_set: got %b want 1", spi_ovf);
      end
      tick();
      total++;
      if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h51, 8'h22}) begin
         bad++;
         $display("FAIL ovf_second_data: got en=%b we=%b a=%h d=%h want 1 1 51 22", ram_en, ram_we, ram_addr, ram_wdata);
      end
      repeat (4) tick();
      total++;
      if ({wr_cnt - w0, spi_ovf} !== {32'd1, 1'b1}) begin
         bad++;
         $display("FAIL ovf_single_write: writes got %0d ovf=%b want 1 1", wr_cnt - w0, spi_ovf);
      end
   endtask

   task automatic test_reset_rd_wait();
      loc_req  = 1'b1;
      loc_we   = 1'b0;
      loc_addr = 8'h20;
      tick();
      tick();
      loc_req = 1'b0;
      rst_n   = 1'b0;
      tick();
      total++;
      if ({tx_data, tx_valid, loc_gnt, loc_rdata, loc_rvalid, ram_en, ram_we,
           ram_addr, ram_wdata, spi_ovf} !== 38'd0) begin
         bad++;
         $display("FAIL reset_mid_outputs: got tx=%h/%b gnt=%b lr=%h/%b en=%b we=%b a=%h wd=%h ovf=%b want all 0",
                  tx_data, tx_valid, loc_gnt, loc_rdata, loc_rvalid, ram_en, ram_we, ram_addr, ram_wdata, spi_ovf);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if ({loc_rvalid, tx_valid, ram_en} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_quiet cycle %0d: got rv=%b tv=%b en=%b want 0 0 0", i, loc_rvalid, tx_valid, ram_en);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      rx_data   = '0;
      rx_valid  = 1'b0;
      loc_req   = 1'b0;
      loc_we    = 1'b0;
      loc_addr  = '0;
      loc_wdata = '0;
      pre_en    = 1'b0;
      pre_addr  = '0;
      pre_data  = '0;
      test_reset();
      test_spi_write();
      test_spi_read();
      test_contention();
      test_held_rx_valid();
      test_overrun();
      test_reset_rd_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave and the single-port RAM.
- Decodes the SPI 10-bit command stream (rx_data/rx_valid) into RAM accesses and returns read data to the slave via tx_data/tx_valid.
- Shares the RAM port with a local host requester using round-robin arbitration.
- Issues at most one RAM access at a time.

Parameters:
- ADDR_W, 8, RAM address width; SPI command payload width equals ADDR_W.
- DATA_W, 8, RAM data width; must equal ADDR_W.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rx_data  in  ADDR_W+2  SPI command: [ADDR_W+1:ADDR_W] opcode, [ADDR_W-1:0] payload
- rx_valid  in  1  SPI command valid; level signal, one command per rising edge
- tx_data  out  DATA_W  read data to SPI slave
- tx_valid  out  1  tx_data valid; held high until next SPI command edge
- loc_req  in  1  local request; held high until loc_gnt is seen
- loc_we  in  1  local write (1) / read (0); stable while loc_req is high
- loc_addr  in  ADDR_W  local address
- loc_wdata  in  DATA_W  local write data
- loc_gnt  out  1  one-cycle grant pulse; coincides with the RAM access cycle
- loc_rdata  out  DATA_W  local read data
- loc_rvalid  out  1  one-cycle pulse; loc_rdata valid
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after ram_en with ram_we=0
- spi_ovf  out  1  sticky overrun flag

Behaviour:
- Reset: all outputs 0. wr_ptr, rd_ptr, spi_pend, last_winner (SPI) and the rx_valid delay register are all 0. State is IDLE.
- SPI command capture: cmd_edge = rx_valid & ~rx_valid_d. Only cmd_edge acts; a held rx_valid is ignored.
- Opcode 00: wr_ptr <= payload. No RAM access.
- Opcode 10: rd_ptr <= payload. No RAM access.
- Opcode 01: spi_pend <= 1, write op. Snapshot addr = wr_ptr, data = payload. Then wr_ptr <= wr_ptr+1, wrapping 2^ADDR_W-1 -> 0.
- Opcode 11: spi_pend <= 1, read op. Snapshot addr = rd_ptr. Then rd_ptr <= rd_ptr+1, with the same wrap.
- Overrun: an 01/11 edge while spi_pend=1 and the pending command has not yet been issued sets spi_ovf=1. The new command overwrites the snapshot. spi_ovf clears only on reset.
- Address commands never disturb a pending snapshot.
- tx_valid: cleared on any cmd_edge. Set in the cycle after an SPI read capture. If both occur in the same cycle, set wins.
- State machine:
  - IDLE: if spi_pend or loc_req, choose a winner and go to ISSUE; otherwise stay.
  - Winner selection: only one requester pending -> that one. Both pending -> the one that is not last_winner. last_winner <= winner.
  - ISSUE: ram_en=1, with ram_we/ram_addr/ram_wdata from the winner. An SPI winner clears spi_pend this cycle, unless a cmd_edge 01/11 arrives now, which re-sets it. A local winner drives loc_gnt=1 this cycle. Write -> IDLE; read -> RD_WAIT.
  - RD_WAIT: ram_en=0. Register ram_rdata into tx_data (SPI) or loc_rdata (local). tx_valid/loc_rvalid are asserted in the following cycle. -> IDLE.
- Latency (request seen in IDLE at cycle T):
  - RAM access at T+1.
  - Read data on tx_data/loc_rdata at T+3.
  - Next arbitration at T+2 for a write, T+3 for a read.
- Requester rule: the local host may change or drop loc_req only in the cycle after loc_gnt. Dropping loc_req before grant withdraws the request with no access.
- Outputs ram_en/ram_we/ram_addr/ram_wdata/loc_gnt are registered, with no combinational input-to-output paths. ram_we=0 whenever ram_en=0.
- Reset mid-operation: any pending, in-flight or captured data is discarded. No rvalid/tx_valid is produced afterwards.

Test Plan:
- SPI write: edges 0x0_10 (00, addr 0x10), then 0x1_A5 (01, data 0xA5) -> one ram_en with ram_we=1, addr 0x10, wdata 0xA5; wr_ptr becomes 0x11.
- SPI read with wrap: RAM[0xFF]=0x3C, edges 0x2_FF then 0x3_00 -> ram_en with addr 0xFF, ram_we=0; tx_data=0x3C and tx_valid=1 three cycles after arbitration; rd_ptr=0x00; tx_valid stays high until the next cmd_edge.
- Contention: spi_pend and loc_req (read 0x20) pending together with last_winner=SPI -> local is granted first (loc_gnt, addr 0x20), SPI on the next arbitration; reversed when last_winner=local.
- Held rx_valid: rx_valid high for 20 cycles with opcode 01 -> exactly one RAM write.
- Overrun: two 01 edges while the local port holds the RAM -> spi_ovf=1; only the second data value is written.
- Reset during RD_WAIT of a local read -> no loc_rvalid; all outputs 0 next cycle; state IDLE.
